// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter between two byte sources:
//   A - packet framer (debug). Holds the channel from grant until the byte
//       flagged a_last has drained; never preempted mid-packet.
//   B - random-byte source. Holds the channel for at most B_BURST bytes per
//       grant, or until it drops b_want.
//
// Optional feature (macro TXARB_ROUND_ROBIN_EN):
//   defined   - on a simultaneous want in IDLE the requester not served last
//               wins; a last-served pointer updates on every grant.
//   undefined - A always wins a simultaneous want; no pointer exists.
//
// Parameters
//   B_BURST          maximum bytes B may send per grant (1..16)
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   a_want           A wants the channel (level)
//   a_req            one-cycle pulse, A presents a_byte
//   a_byte[7:0]      A data byte
//   a_last           qualifies a_req, byte ends A's packet
//   a_busy           low only while A owns the channel
//   b_want           B wants the channel (level)
//   b_req            one-cycle pulse, B presents b_byte
//   b_byte[7:0]      B data byte
//   b_busy           low only while B owns the channel
//   is_transmitting  UART transmitter busy
//   tx_byte[7:0]     byte to the UART
//   transmit         one-cycle pulse, tx_byte valid
//   owner[1:0]       00 none, 01 A, 10 B
//   pkt_cnt[15:0]    completed A packets (wraps)
//   proto_err        sticky: a req arrived while that requester was busy
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned B_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_want,
  input  logic        a_req,
  input  logic [7:0]  a_byte,
  input  logic        a_last,
  output logic        a_busy,
  input  logic        b_want,
  input  logic        b_req,
  input  logic [7:0]  b_byte,
  output logic        b_busy,
  input  logic        is_transmitting,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  output logic [1:0]  owner,
  output logic [15:0] pkt_cnt,
  output logic        proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OWN_A,
    S_OWN_B,
    S_SEND,
    S_DRAIN
  } state_t;

  // Burst counter holds bytes already sent in this grant; the byte draining
  // now is the last one allowed when the counter equals B_BURST-1.
  localparam logic [4:0] BURST_LAST = 5'(B_BURST - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_own_b;        // owner remembered through SEND/DRAIN
  logic        r_last;         // latched a_last of the byte in flight
  logic [7:0]  r_tx_byte;
  logic        r_drain_first;  // first DRAIN cycle ignores is_transmitting
  logic [4:0]  r_bcnt;
  logic [15:0] r_pkt_cnt;
  logic        r_proto_err;

  logic        w_a_busy;
  logic        w_b_busy;
  logic        w_proto_viol;
  logic        w_pick_b;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_load_a;
  logic        w_load_b;
  logic        w_pkt_inc;
  logic        w_burst_inc;
  logic        w_burst_clr;

`ifdef TXARB_ROUND_ROBIN_EN
  logic        r_rr_last_b;    // 1: B was served last, so A wins a tie

  assign w_pick_b = ~r_rr_last_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last_b <= 1'b1;
    end else if (w_grant_a) begin
      r_rr_last_b <= 1'b0;
    end else if (w_grant_b) begin
      r_rr_last_b <= 1'b1;
    end
  end
`else
  assign w_pick_b = 1'b0;
`endif

  assign w_a_busy = (r_state != S_OWN_A);
  assign w_b_busy = (r_state != S_OWN_B);

  // Offending bytes are simply not loaded: the FSM only honours a_req in
  // OWN_A and b_req in OWN_B, so the violation never disturbs state.
  assign w_proto_viol = (a_req && w_a_busy) || (b_req && w_b_busy);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_pkt_inc   = 1'b0;
    w_burst_inc = 1'b0;
    w_burst_clr = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (a_want && b_want) begin
          if (w_pick_b) begin
            w_grant_b = 1'b1;
          end else begin
            w_grant_a = 1'b1;
          end
        end else if (a_want) begin
          w_grant_a = 1'b1;
        end else if (b_want) begin
          w_grant_b = 1'b1;
        end

        if (w_grant_a) begin
          w_next = S_OWN_A;
        end else if (w_grant_b) begin
          w_next = S_OWN_B;
        end
      end

      S_OWN_A: begin
        if (a_req) begin
          w_load_a = 1'b1;
          w_next   = S_SEND;
        end else if (!a_want) begin
          // Packet abandoned; pkt_cnt untouched.
          w_next = S_IDLE;
        end
      end

      S_OWN_B: begin
        if (b_req) begin
          w_load_b = 1'b1;
          w_next   = S_SEND;
        end else if (!b_want) begin
          w_burst_clr = 1'b1;
          w_next      = S_IDLE;
        end
      end

      S_SEND: begin
        w_next = S_DRAIN;
      end

      S_DRAIN: begin
        if (!r_drain_first && !is_transmitting) begin
          if (!r_own_b) begin
            if (r_last) begin
              w_pkt_inc = 1'b1;
              w_next    = S_IDLE;
            end else begin
              w_next = S_OWN_A;
            end
          end else begin
            if (r_bcnt == BURST_LAST) begin
              w_burst_clr = 1'b1;
              w_next      = S_IDLE;
            end else begin
              w_burst_inc = 1'b1;
              w_next      = S_OWN_B;
            end
          end
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_own_b       <= 1'b0;
      r_last        <= 1'b0;
      r_tx_byte     <= '0;
      r_drain_first <= 1'b0;
      r_bcnt        <= '0;
      r_pkt_cnt     <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_drain_first <= (r_state == S_SEND);

      if (w_grant_a) begin
        r_own_b <= 1'b0;
      end else if (w_grant_b) begin
        r_own_b <= 1'b1;
      end

      if (w_load_a) begin
        r_tx_byte <= a_byte;
        r_last    <= a_last;
      end else if (w_load_b) begin
        r_tx_byte <= b_byte;
      end

      if (w_burst_clr) begin
        r_bcnt <= '0;
      end else if (w_burst_inc) begin
        r_bcnt <= r_bcnt + 5'd1;
      end

      if (w_pkt_inc) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end

      if (w_proto_viol) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset acts immediately)
  // -------------------------------------------------------------------------
  always_comb begin
    owner = 2'b00;
    case (r_state)
      S_OWN_A:         owner = 2'b01;
      S_OWN_B:         owner = 2'b10;
      S_SEND, S_DRAIN: owner = r_own_b ? 2'b10 : 2'b01;
      default:         owner = 2'b00;
    endcase
  end

  assign a_busy    = w_a_busy;
  assign b_busy    = w_b_busy;
  assign transmit  = (r_state == S_SEND);
  assign tx_byte   = r_tx_byte;
  assign pkt_cnt   = r_pkt_cnt;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (B_BURST = 4). A small UART model
// holds is_transmitting high for uart_len cycles after each transmit pulse.
// Expectations for tie-break arbitration follow TXARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_want = 1'b0;
  logic        a_req = 1'b0;
  logic [7:0]  a_byte = '0;
  logic        a_last = 1'b0;
  logic        a_busy;
  logic        b_want = 1'b0;
  logic        b_req = 1'b0;
  logic [7:0]  b_byte = '0;
  logic        b_busy;
  logic        is_transmitting = 1'b0;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic [1:0]  owner;
  logic [15:0] pkt_cnt;
  logic        proto_err;

  int checks = 0;
  int passed = 0;
  int uart_len = 0;
  int urem = 0;
  logic [7:0] txq[$];

  uart_tx_arbiter #(.B_BURST(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a_want          (a_want),
    .a_req           (a_req),
    .a_byte          (a_byte),
    .a_last          (a_last),
    .a_busy          (a_busy),
    .b_want          (b_want),
    .b_req           (b_req),
    .b_byte          (b_byte),
    .b_busy          (b_busy),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .owner           (owner),
    .pkt_cnt         (pkt_cnt),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // UART model: busy for uart_len cycles, starting in the SEND cycle.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      is_transmitting = 1'b0;
      urem = 0;
    end else if (transmit === 1'b1 && uart_len > 0) begin
      is_transmitting = 1'b1;
      urem = uart_len;
    end else if (urem > 0) begin
      urem--;
      if (urem == 0) is_transmitting = 1'b0;
    end
  end

  // Record every byte handed to the UART.
  always @(negedge clk) begin
    if (transmit === 1'b1) txq.push_back(tx_byte);
  end

  // Stimulus helpers (no checking; callers inspect ok).
  task automatic do_reset();
    a_want = 1'b0; a_req = 1'b0; a_last = 1'b0;
    b_want = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txq.delete();
  endtask

  // Returns at the negedge of the SEND cycle for the offered byte.
  task automatic send_a(input logic [7:0] d, input logic l, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      a_req = 1'b1; a_byte = d; a_last = l;
      @(negedge clk);
      a_req = 1'b0; a_last = 1'b0;
    end
  endtask

  task automatic send_b(input logic [7:0] d, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (b_busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      b_req = 1'b1; b_byte = d;
      @(negedge clk);
      b_req = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (owner === 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    a_want = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (owner !== 2'b00) $display("FAIL reset_owner got=%b exp=00", owner); else passed++;
    checks++; if (a_busy !== 1'b1) $display("FAIL reset_a_busy got=%b exp=1", a_busy); else passed++;
    checks++; if (b_busy !== 1'b1) $display("FAIL reset_b_busy got=%b exp=1", b_busy); else passed++;
    checks++; if (transmit !== 1'b0) $display("FAIL reset_transmit got=%b exp=0", transmit); else passed++;
    checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); else passed++;
    checks++; if (pkt_cnt !== 16'h0) $display("FAIL reset_pkt_cnt got=%h exp=0000", pkt_cnt); else passed++;
    checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b exp=0", proto_err); else passed++;
    a_want = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_a_packet();
    logic [7:0] pkt [4];
    bit ok;
    pkt[0] = 8'h55; pkt[1] = 8'h12; pkt[2] = 8'h34; pkt[3] = 8'hAA;
    do_reset();
    uart_len = 10;
    a_want = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_a(pkt[k], (k == 3), ok);
      if (k == 3) a_want = 1'b0;
      checks++; if (!ok) $display("FAIL a_pkt_grant byte=%0d got=timeout exp=a_busy_low", k); else passed++;
      // One cycle after the req the pulse must be up with the byte.
      checks++; if (transmit !== 1'b1 || tx_byte !== pkt[k])
        $display("FAIL a_pkt_tx byte=%0d got=%b/%h exp=1/%h", k, transmit, tx_byte, pkt[k]);
      else passed++;
    end
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL a_pkt_idle got=owner %b exp=00", owner); else passed++;
    checks++; if (pkt_cnt !== 16'd1) $display("FAIL a_pkt_cnt got=%0d exp=1", pkt_cnt); else passed++;
    checks++; if (txq.size() != 4) $display("FAIL a_pkt_count got=%0d exp=4", txq.size()); else passed++;
    for (int k = 0; k < 4 && k < txq.size(); k++) begin
      checks++; if (txq[k] !== pkt[k]) $display("FAIL a_pkt_order idx=%0d got=%h exp=%h", k, txq[k], pkt[k]); else passed++;
    end
  endtask

  task automatic test_b_burst();
    int accepted;
    bit ok;
    do_reset();
    uart_len = 3;
    accepted = 0;
    b_want = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send_b(8'hB0 + 8'(k), 40, ok);
      if (!ok) break;
      accepted++;
      a_want = 1'b1;
    end
    checks++; if (accepted != 4) $display("FAIL b_burst_accepted got=%0d exp=4", accepted); else passed++;
    checks++; if (txq.size() != 4) $display("FAIL b_burst_sent got=%0d exp=4", txq.size()); else passed++;
    for (int k = 0; k < 4 && k < txq.size(); k++) begin
      checks++; if (txq[k] !== 8'hB0 + 8'(k)) $display("FAIL b_burst_byte idx=%0d got=%h exp=%h", k, txq[k], 8'hB0 + 8'(k)); else passed++;
    end
    checks++; if (owner !== 2'b01) $display("FAIL b_burst_next_owner got=%b exp=01", owner); else passed++;
    checks++; if (proto_err !== 1'b0) $display("FAIL b_burst_proto got=%b exp=0", proto_err); else passed++;
    a_want = 1'b0; b_want = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_arbitration();
    logic [1:0] exp2;
    bit ok;
`ifdef TXARB_ROUND_ROBIN_EN
    exp2 = 2'b10;
`else
    exp2 = 2'b01;
`endif
    do_reset();
    uart_len = 0;
    a_want = 1'b1; b_want = 1'b1;
    @(negedge clk);
    checks++; if (owner !== 2'b01) $display("FAIL arb_first got=%b exp=01", owner); else passed++;
    a_want = 1'b0; b_want = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL arb_release got=%b exp=00", owner); else passed++;
    a_want = 1'b1; b_want = 1'b1;
    @(negedge clk);
    checks++; if (owner !== exp2) $display("FAIL arb_second got=%b exp=%b", owner, exp2); else passed++;
    a_want = 1'b0; b_want = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_proto_err();
    bit ok;
    do_reset();
    uart_len = 2;
    a_want = 1'b1;
    send_a(8'h11, 1'b0, ok);
    b_req = 1'b1; b_byte = 8'hEE;
    @(negedge clk);
    b_req = 1'b0;
    checks++; if (proto_err !== 1'b1) $display("FAIL proto_set got=%b exp=1", proto_err); else passed++;
    checks++; if (tx_byte !== 8'h11) $display("FAIL proto_tx_byte got=%h exp=11", tx_byte); else passed++;
    send_a(8'h22, 1'b1, ok);
    a_want = 1'b0;
    wait_idle(ok);
    checks++; if (pkt_cnt !== 16'd1) $display("FAIL proto_pkt_cnt got=%0d exp=1", pkt_cnt); else passed++;
    checks++; if (txq.size() != 2 || txq[0] !== 8'h11 || txq[1] !== 8'h22)
      $display("FAIL proto_stream got=%0d bytes exp=11,22", txq.size());
    else passed++;
    repeat (3) @(negedge clk);
    checks++; if (proto_err !== 1'b1) $display("FAIL proto_sticky got=%b exp=1", proto_err); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int pulses;
    do_reset();
    uart_len = 10;
    a_want = 1'b1;
    send_a(8'h55, 1'b0, ok);
    send_a(8'h12, 1'b0, ok);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    a_want = 1'b0;
    #1;
    checks++; if (owner !== 2'b00 || a_busy !== 1'b1 || b_busy !== 1'b1)
      $display("FAIL midrst_ctrl got=%b/%b/%b exp=00/1/1", owner, a_busy, b_busy);
    else passed++;
    checks++; if (tx_byte !== 8'h00 || transmit !== 1'b0)
      $display("FAIL midrst_data got=%h/%b exp=00/0", tx_byte, transmit);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (transmit === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL midrst_no_tx got=%0d exp=0", pulses); else passed++;
  endtask

  task automatic test_pkt_wrap();
    bit ok;
    do_reset();
    uart_len = 0;
    @(negedge clk);
    force dut.r_pkt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_pkt_cnt;
    @(negedge clk);
    checks++; if (pkt_cnt !== 16'hFFFF) $display("FAIL wrap_preset got=%h exp=ffff", pkt_cnt); else passed++;
    a_want = 1'b1;
    send_a(8'h7E, 1'b1, ok);
    a_want = 1'b0;
    wait_idle(ok);
    checks++; if (pkt_cnt !== 16'h0000) $display("FAIL wrap_cnt got=%h exp=0000", pkt_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_a_packet();
    test_b_burst();
    test_arbitration();
    test_proto_err();
    test_reset_mid();
    test_pkt_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter B_BURST, default 4, legal range 1..16: maximum bytes requester B may send per grant.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port a_want, input, 1: packet requester A (debug framer) wants the channel (level).
REQ-005 Port a_req, input, 1: one-cycle pulse; A presents a_byte.
REQ-006 Port a_byte, input, 8: A data byte.
REQ-007 Port a_last, input, 1: qualifies a_req; the byte is the last of A's packet.
REQ-008 Port a_busy, output, 1: low only while A owns the channel and a byte may be offered.
REQ-009 Port b_want, b_req, b_byte, b_busy: same meaning for random-byte requester B; B has no last flag.
REQ-010 Port is_transmitting, input, 1: UART transmitter busy.
REQ-011 Port tx_byte, output, 8: byte to the UART.
REQ-012 Port transmit, output, 1: one-cycle pulse; tx_byte is valid.
REQ-013 Port owner, output, 2: 00 none, 01 A, 10 B.
REQ-014 Port pkt_cnt, output, 16: completed A packets, wrapping at 16'hFFFF -> 0.
REQ-015 Port proto_err, output, 1: sticky protocol-error flag.

Function
REQ-016 FSM states: IDLE, OWN_A, OWN_B, SEND, DRAIN; SEND and DRAIN remember the owner.
REQ-017 IDLE: a_want only -> OWN_A; b_want only -> OWN_B; both -> arbitration per REQ-031/032; neither -> stay.
REQ-018 a_busy = 0 exactly in OWN_A; b_busy = 0 exactly in OWN_B; otherwise 1.
REQ-019 OWN_x with x_req = 1: latch x_byte into tx_byte, latch a_last (A only), go to SEND.
REQ-020 SEND: transmit = 1 for exactly that cycle, then go to DRAIN.
REQ-021 DRAIN: first cycle unconditional; from the second cycle, exit when is_transmitting = 0.
REQ-022 Request-to-transmit latency: 1 cycle; minimum byte period: 4 cycles.
REQ-023 DRAIN exit, owner A: if the latched last = 1, increment pkt_cnt and go to IDLE; else return to OWN_A.
REQ-024 DRAIN exit, owner B: increment burst count; if count = B_BURST, go to IDLE and clear count; else return to OWN_B.
REQ-025 OWN_A with a_want = 0 and no a_req: go to IDLE; packet abandoned; pkt_cnt unchanged.
REQ-026 OWN_B with b_want = 0 and no b_req: go to IDLE; clear burst count.
REQ-027 Dropping x_want during SEND/DRAIN is ignored until DRAIN exits.
REQ-028 A is never preempted mid-packet; B's want is held off until A's last byte drains.
REQ-029 Set proto_err when x_req = 1 while x_busy = 1, including simultaneous a_req and b_req; the offending byte is discarded; state is unaffected.
REQ-030 owner output reflects the current owner; 00 in IDLE.

Configuration
REQ-031 Macro TXARB_ROUND_ROBIN_EN defined: on a simultaneous want in IDLE, grant the requester not served last; the last-served pointer updates on every grant.
REQ-032 Macro TXARB_ROUND_ROBIN_EN undefined: A always wins a simultaneous want; no pointer register exists.

Reset
REQ-033 rst_n = 0 forces immediately: state IDLE, tx_byte 8'h00, transmit 0, a_busy 1, b_busy 1, owner 00, pkt_cnt 0, proto_err 0, burst count 0, last-served pointer = B (A wins first).
REQ-034 Reset mid-byte aborts it; no transmit pulse follows deassertion until a new grant and req.
REQ-035 proto_err clears only on reset.

Verification
REQ-036 A packet 55,12,34,AA (last on AA); is_transmitting high 10 cycles per byte -> four transmit pulses in order; pkt_cnt 0 -> 1; owner returns to 00.
REQ-037 B_BURST = 4, b_want held, B offers 6 bytes -> 4 sent, grant released; with a_want high, A is granted next (either macro setting).
REQ-038 a_want and b_want rise in the same IDLE cycle, twice in succession -> with macro: A then B; without macro: A then A.
REQ-039 b_req pulsed while A owns the channel -> proto_err = 1; byte never reaches tx_byte; A's packet completes unaltered.
REQ-040 rst_n low during DRAIN of A's second byte -> outputs at reset values immediately; after release with no req, transmit stays 0.
REQ-041 pkt_cnt preset by 65535 A packets, one more packet -> pkt_cnt = 0.
